// File: rtl/mem_arb_pkg.sv
// Shared constants and response-owner encoding for the memory port arbiter.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W = 8;
    localparam int MEM_ARB_DATA_W = 16;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_IF    = 2'd1,
        OWN_DM_RD = 2'd2
    } resp_own_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; raises force_if at the limit.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_req,
    input  logic if_gnt,
    output logic force_if
);

    localparam int CNT_W = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
    localparam logic [CNT_W-1:0] LIM = CNT_W'(STARVE_LIM);

    logic [CNT_W-1:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (!if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != LIM) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // A limit of zero never forces: pure fixed data-side priority.
    assign force_if = (STARVE_LIM != 0) && (starve_cnt == LIM);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Define MEM_ARB_PERF_EN to add the conflict_cnt / starve_evt_cnt counters.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = MEM_ARB_ADDR_W,
    parameter int DATA_W     = MEM_ARB_DATA_W,
    parameter int STARVE_LIM = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              stall_if,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       starve_evt_cnt
`endif
);

    logic              force_if;
    resp_own_e         resp_own_nxt;
    resp_own_e         resp_own_p1;
    logic [DATA_W-1:0] if_rdata_p1;
    logic [DATA_W-1:0] dm_rdata_p1;

    mem_arb_starve_ctr #(
        .STARVE_LIM(STARVE_LIM)
    ) u_starve (
        .clk     (clk),
        .rst     (rst),
        .if_req  (if_req),
        .if_gnt  (if_gnt),
        .force_if(force_if)
    );

    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (rst) begin
            if (if_req && (!dm_req || force_if)) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end
        end
    end

    assign stall_if = rst && if_req && !if_gnt;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    always_comb begin
        resp_own_nxt = OWN_NONE;
        if (if_gnt) begin
            resp_own_nxt = OWN_IF;
        end else if (dm_gnt && !dm_we) begin
            resp_own_nxt = OWN_DM_RD;
        end
    end

    // ---- grant -> response stage (memory read data arrives here) ----
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_own_p1 <= OWN_NONE;
        end else begin
            resp_own_p1 <= resp_own_nxt;
        end
    end

    // Gating with rst drops a response whose cycle coincides with reset.
    assign if_rvalid = rst && (resp_own_p1 == OWN_IF);
    assign dm_rvalid = rst && (resp_own_p1 == OWN_DM_RD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if_rdata_p1 <= '0;
            dm_rdata_p1 <= '0;
        end else begin
            if (if_rvalid) if_rdata_p1 <= mem_rdata;
            if (dm_rvalid) dm_rdata_p1 <= mem_rdata;
        end
    end

    assign if_rdata = if_rvalid ? mem_rdata : if_rdata_p1;
    assign dm_rdata = dm_rvalid ? mem_rdata : dm_rdata_p1;

`ifdef MEM_ARB_PERF_EN
    // IF can only win against a live data request through the starvation override.
    always_ff @(posedge clk) begin
        if (!rst) begin
            conflict_cnt   <= '0;
            starve_evt_cnt <= '0;
        end else begin
            if (if_req && dm_req && conflict_cnt != 16'hFFFF)
                conflict_cnt <= conflict_cnt + 16'd1;
            if (if_gnt && dm_req && starve_evt_cnt != 16'hFFFF)
                starve_evt_cnt <= starve_evt_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a synchronous-read memory model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              stall_if;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
`ifdef MEM_ARB_PERF_EN
    logic [15:0]       conflict_cnt;
    logic [15:0]       starve_evt_cnt;
`endif

    mem_port_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .STARVE_LIM(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .stall_if (stall_if),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_gnt   (dm_gnt),
        .dm_rvalid(dm_rvalid),
        .dm_rdata (dm_rdata),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
`ifdef MEM_ARB_PERF_EN
        ,
        .conflict_cnt  (conflict_cnt),
        .starve_evt_cnt(starve_evt_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem     [256];
    logic [DATA_W-1:0] ref_mem [256];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    typedef struct {
        bit                own_if;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              q[$];
    int                cyc;
    int                n_chk;
    int                n_pass;
    logic [DATA_W-1:0] last_if;
    logic [DATA_W-1:0] last_dm;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h required %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic check_resp();
        exp_t e;
        if (q.size() > 0 && q[0].due == cyc) begin
            e = q.pop_front();
            chk("if_rvalid", 32'(if_rvalid), 32'(e.own_if));
            chk("dm_rvalid", 32'(dm_rvalid), 32'(!e.own_if));
            if (e.own_if) begin
                chk("if_rdata", 32'(if_rdata), 32'(e.data));
                last_if = e.data;
            end else begin
                chk("dm_rdata", 32'(dm_rdata), 32'(e.data));
                last_dm = e.data;
            end
        end else begin
            chk("rvalid_idle", 32'({if_rvalid, dm_rvalid}), 32'(0));
            chk("if_rdata_hold", 32'(if_rdata), 32'(last_if));
            chk("dm_rdata_hold", 32'(dm_rdata), 32'(last_dm));
        end
    endtask

    task automatic drive(input bit ir, input logic [ADDR_W-1:0] ia,
                         input bit dr, input bit dw, input logic [ADDR_W-1:0] da,
                         input logic [DATA_W-1:0] dwd, input bit eig, input bit edg);
        if_req   = ir;
        if_addr  = ia;
        dm_req   = dr;
        dm_we    = dw;
        dm_addr  = da;
        dm_wdata = dwd;
        @(negedge clk);
        check_resp();
        chk("if_gnt", 32'(if_gnt), 32'(eig));
        chk("dm_gnt", 32'(dm_gnt), 32'(edg));
        chk("stall_if", 32'(stall_if), 32'(ir & ~eig));
        if (edg) begin
            chk("mem_en", 32'(mem_en), 32'(1));
            chk("mem_we", 32'(mem_we), 32'(dw));
            chk("mem_addr", 32'(mem_addr), 32'(da));
            chk("mem_wdata", 32'(mem_wdata), 32'(dwd));
            if (dw) ref_mem[da] = dwd;
            else    q.push_back('{1'b0, ref_mem[da], cyc + 1});
        end else if (eig) begin
            chk("mem_en", 32'(mem_en), 32'(1));
            chk("mem_we", 32'(mem_we), 32'(0));
            chk("mem_addr", 32'(mem_addr), 32'(ia));
            chk("mem_wdata", 32'(mem_wdata), 32'(0));
            q.push_back('{1'b1, ref_mem[ia], cyc + 1});
        end else begin
            chk("mem_en_idle", 32'(mem_en), 32'(0));
            chk("mem_addr_idle", 32'(mem_addr), 32'(0));
            chk("mem_wdata_idle", 32'(mem_wdata), 32'(0));
        end
        @(posedge clk); #1; cyc++;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_if_gnt"}, 32'(if_gnt), 32'(0));
        chk({tag, "_dm_gnt"}, 32'(dm_gnt), 32'(0));
        chk({tag, "_stall"}, 32'(stall_if), 32'(0));
        chk({tag, "_mem_en"}, 32'(mem_en), 32'(0));
        chk({tag, "_if_rvalid"}, 32'(if_rvalid), 32'(0));
        chk({tag, "_dm_rvalid"}, 32'(dm_rvalid), 32'(0));
    endtask

    task automatic do_reset();
        rst = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
        if_addr = 8'h07; dm_addr = 8'h07; dm_wdata = '0;
        @(posedge clk); #1; cyc++;
        @(negedge clk);
        check_reset_outputs("rst");
        chk("rst_if_rdata", 32'(if_rdata), 32'(0));
        chk("rst_dm_rdata", 32'(dm_rdata), 32'(0));
`ifdef MEM_ARB_PERF_EN
        chk("rst_conflict_cnt", 32'(conflict_cnt), 32'(0));
        chk("rst_starve_evt_cnt", 32'(starve_evt_cnt), 32'(0));
`endif
        @(posedge clk); #1; cyc++;
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        q.delete();
        last_if = '0;
        last_dm = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0;
        mem_rdata = '0;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 16'h1000 + 16'(i);
            ref_mem[i] = 16'h1000 + 16'(i);
        end
        do_reset();

        // five conflicts; the fifth is a starvation override
        for (int i = 0; i < 5; i++)
            drive(1'b1, 8'h08, 1'b1, 1'b0, 8'h40, '0, i == 4, i != 4);
`ifdef MEM_ARB_PERF_EN
        chk("conflict_cnt", 32'(conflict_cnt), 32'(5));
        chk("starve_evt_cnt", 32'(starve_evt_cnt), 32'(1));
`endif
        idle();

        for (int i = 0; i < 3; i++)
            drive(1'b1, 8'(i), 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle();

        drive(1'b1, 8'h03, 1'b1, 1'b0, 8'h20, '0, 1'b0, 1'b1);
        drive(1'b1, 8'h03, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle();

        drive(1'b0, '0, 1'b1, 1'b1, 8'h30, 16'hBEEF, 1'b0, 1'b1);
        drive(1'b1, 8'h30, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle();

        for (int i = 0; i < 10; i++)
            drive(1'b1, 8'h0A, 1'b1, 1'b0, 8'h41, '0, (i == 4) || (i == 9), !((i == 4) || (i == 9)));
        idle();

        // fetch granted, then reset lands on its response cycle
        if_req = 1'b1; if_addr = 8'h05; dm_req = 1'b0; dm_we = 1'b0;
        @(negedge clk);
        chk("pre_rst_if_gnt", 32'(if_gnt), 32'(1));
        @(posedge clk); #1; cyc++;
        rst = 1'b0; dm_req = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        @(posedge clk); #1; cyc++;
        last_if = '0;
        last_dm = '0;
        @(negedge clk);
        check_reset_outputs("in_rst");
        chk("in_rst_if_rdata", 32'(if_rdata), 32'(0));
        chk("in_rst_dm_rdata", 32'(dm_rdata), 32'(0));
        @(posedge clk); #1; cyc++;
        rst = 1'b1;
        drive(1'b1, 8'h05, 1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
        idle();
        idle();

        chk("queue_empty", 32'(q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read program/data memory between two requesters:
  - the IF stage: instruction fetch, read-only;
  - the MEM stage: data load/store.
- Sits between the pipeline and the memory array.
- Issues at most one memory access per cycle and routes the 1-cycle-latency read data back to its owner.
- Generates a fetch stall when IF loses arbitration.
- Includes a starvation guard so IF cannot be locked out indefinitely.

Parameters:
- ADDR_W, 8, memory address width in words.
- DATA_W, 16, word width (instruction size).
- STARVE_LIM, 4, consecutive denied IF cycles before IF gets forced priority; 0 = pure fixed DM priority.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- if_req  in  1  fetch request.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted this cycle (combinational).
- if_rvalid  out  1  fetch data valid (registered).
- if_rdata  out  DATA_W  fetched instruction.
- stall_if  out  1  if_req & ~if_gnt.
- dm_req  in  1  data request.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data.
- dm_gnt  out  1  data access accepted this cycle (combinational).
- dm_rvalid  out  1  load data valid (registered).
- dm_rdata  out  DATA_W  load data.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid the cycle after mem_en & ~mem_we.

Behaviour:
- Arbitration (combinational, same cycle):
  - Only one requester active: it is granted.
  - Both active: DM wins, unless starve_cnt == STARVE_LIM and STARVE_LIM != 0, in which case IF wins.
- Granted request drives mem_en = 1, mem_we = dm_we (0 for IF), mem_addr, mem_wdata (0 for IF).
- No request: mem_en = 0, mem_we = 0, mem_addr/mem_wdata hold 0.
- Starvation counter starve_cnt, width clog2(STARVE_LIM+1), registered:
  - increments when if_req & ~if_gnt;
  - clears when if_gnt or ~if_req;
  - saturates at STARVE_LIM.
- Response-owner register resp_own: NONE / IF / DM_RD. Loaded each cycle:
  - IF when IF granted;
  - DM_RD when DM load granted;
  - NONE otherwise, including stores.
- Cycle after the grant:
  - resp_own == IF: if_rvalid = 1, if_rdata = mem_rdata, registered.
  - resp_own == DM_RD: dm_rvalid = 1, dm_rdata = mem_rdata, registered.
  - if_rdata/dm_rdata hold their last value when their rvalid = 0.
- Read latency: 1 cycle from grant to rvalid at the arbiter outputs, since the memory is itself registered.
- Back-to-back grants to either requester are allowed every cycle; throughput 1 access/cycle.
- Stores complete on the grant cycle. No response is produced; dm_gnt is the acknowledgement.
- Simultaneous same-address IF read and DM store: DM wins (absent starvation). When starvation forces IF, the store is deferred; the requester holds dm_req.
- Requesters must hold req/addr/data stable until granted; the arbiter does not latch ungranted requests.
- Reset (rst == 0 at a clock edge):
  - starve_cnt = 0, resp_own = NONE;
  - if_rvalid = dm_rvalid = 0, if_rdata = dm_rdata = 0.
  - While rst is low, grants, mem_en and stall_if are forced to 0.
  - Reset asserted the cycle after a grant: the pending response is dropped; no rvalid is asserted.

Optional Feature:
- MEM_ARB_PERF_EN defined: adds output ports conflict_cnt (16 bits) and starve_evt_cnt (16 bits).
  - conflict_cnt: cycles with if_req & dm_req.
  - starve_evt_cnt: cycles where the starvation override granted IF.
  - Both saturate at 16'hFFFF and clear on reset.
- Not defined: ports and logic absent; the remaining behaviour is identical.

Decomposition:
- Shared package mem_arb_pkg:
  - default ADDR_W and DATA_W constants;
  - resp_own encoding (NONE = 2'd0, IF = 2'd1, DM_RD = 2'd2).
- One natural sub-module, mem_arb_starve_ctr: the saturating starvation counter and force-priority flag.
- Grant and owner logic stays in the top level.

Test Plan:
- Reset then IF-only fetches at addresses 0,1,2 with memory model word = 16'h1000 + addr -> if_gnt = 1 each cycle; if_rvalid 1 cycle later with 16'h1000, 16'h1001, 16'h1002; stall_if = 0.
- IF and DM load both requesting, dm_addr = 8'h20 for 1 cycle -> dm_gnt = 1, if_gnt = 0, stall_if = 1; next cycle dm_rvalid = 1, dm_rdata = 16'h1020, if_rvalid = 0.
- Store dm_we = 1, addr 8'h30, data 16'hBEEF, then IF fetch of 8'h30 -> mem_we = 1 on cycle 0; no dm_rvalid; IF later returns 16'hBEEF.
- STARVE_LIM = 4, dm_req held high with if_req high for 10 cycles -> IF denied cycles 0-3, granted cycle 4, counter clears, IF denied cycles 5-8, granted cycle 9.
- IF granted at cycle N, rst low at edge N+1 -> if_rvalid stays 0; all outputs 0 while rst is low; normal grant on first cycle after release.
- With MEM_ARB_PERF_EN, 5 conflict cycles incl. 1 starvation override (STARVE_LIM = 4) -> conflict_cnt = 5, starve_evt_cnt = 1.
